edge_result_collector: RTL and testbench
========================================

# edge_result_collector

Downstream stage of the multi-edge arithmetic block: samples each result pair (c, f) it produces into a small first-word-fall-through buffer and hands the pairs to the consumer over a valid/ready handshake. It flags results lost to back-pressure and, optionally, keeps a saturating running sum of f. Single clock domain, posedge only; all outputs registered or decoded from registered state.

## Interface
- DATA_W, 8, width of each result (c and f)
- DEPTH, 4, buffer entries; power of two, ≥ 2
- SUM_W, 16, width of running sum of f (used only with macro)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a new (c, f) pair is present this cycle
- in_c  input  DATA_W  result c from upstream stage
- in_f  input  DATA_W  result f from upstream stage
- clear  input  1  synchronous clear of overflow, sum_f, sum_sat
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_c  output  DATA_W  head entry c; 0 when out_valid=0
- out_f  output  DATA_W  head entry f; 0 when out_valid=0
- count  output  $clog2(DEPTH)+1  entries currently held, 0..DEPTH
- overflow  output  1  sticky: an input pair was dropped
- sum_f  output  SUM_W  saturating sum of accepted f values (macro only)
- sum_sat  output  1  sticky: sum_f saturated (macro only)

## Operation
- pop = out_valid && out_ready; push = in_valid && (count < DEPTH || pop).
- Push writes {in_c, in_f} at write pointer; pop advances read pointer. Pointers wrap modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (count=DEPTH) with in_valid and no pop: pair dropped, nothing stored, overflow set next cycle.
- Full with in_valid and pop in the same cycle: pair accepted, count stays DEPTH.
- Empty with in_valid: stored; there is no bypass to the outputs in the same cycle.
- out_valid = (count != 0); out_c/out_f present the entry at the read pointer, forced to 0 when empty.
- clear: overflow←0, sum_f←0, sum_sat←0 next cycle. It does not affect buffer contents, pointers or count. clear takes priority over a same-cycle overflow set or accumulation; the pushed pair is still stored.
- Accumulation (macro): on each push, sum_f ← sum_f + zero-extended in_f. If the true result exceeds 2^SUM_W−1, sum_f ← 2^SUM_W−1 and sum_sat←1. Once saturated, sum_f holds until clear.

## Timing
- Reset (rst_n low, asynchronous): pointers, count, overflow, sum_f, sum_sat = 0. Outputs: out_valid=0, out_c=0, out_f=0, count=0.
- Reset asserted mid-operation discards all entries immediately; the first push after release is accepted on the first rising edge with rst_n high.
- Latency: push at edge N makes out_valid=1 with that data after edge N (visible in cycle N+1).
- Pop at edge N exposes the next entry, or zeros if empty, after edge N.
- Throughput: one push and one pop per cycle sustained, at any fill level.
- Handshake: out_c/out_f hold stable while out_valid=1 and out_ready=0.
- out_ready is ignored when out_valid=0; no underflow is possible.

## Configuration
- Macro EDGE_COLLECTOR_SUM_EN.
- Defined: sum_f and sum_sat ports and the accumulator logic exist, as described above.
- Undefined: the accumulator, sum_f and sum_sat are compiled out entirely. Ports are absent, and buffer behaviour is identical.

## Structure
- Shared package edge_collector_pkg holds the DATA_W/SUM_W defaults and the result-pair struct type {c, f}.
- One sub-module, edge_collector_fifo, is natural: storage, pointers, count and push/pop qualification. The top adds overflow, clear and the optional accumulator.

## Test plan
- Reset, then in_valid with c=50, f=80 for one cycle, out_ready=0 → next cycle out_valid=1, out_c=50, out_f=80, count=1; held for 3 idle cycles.
- Push 5 pairs (f=1..5) with out_ready=0, DEPTH=4 → count=4, 5th dropped, overflow=1. Pop all → f order 1,2,3,4, then out_valid=0, out_f=0.
- Full buffer, in_valid and out_ready together for 6 cycles → count stays 4, no overflow, outputs in FIFO order across pointer wrap.
- With macro: push f=200 ×400, SUM_W=16 → sum_f saturates at 65535, sum_sat=1. clear in the same cycle as a push → sum_f=0, pushed pair still stored.
- clear while overflow=1 and in a dropped-push cycle → overflow=0 next cycle.
- rst_n low mid-stream with count=3 → out_valid, count, overflow and out_* drop to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/edge_collector_pkg.sv
// rtl/edge_collector_pkg.sv - shared defaults and result-pair type for the edge result collector
package edge_collector_pkg;

  localparam int COLLECTOR_DATA_W = 8;
  localparam int COLLECTOR_SUM_W  = 16;
  localparam int COLLECTOR_DEPTH  = 4;

  typedef struct packed {
    logic [COLLECTOR_DATA_W-1:0] c;
    logic [COLLECTOR_DATA_W-1:0] f;
  } result_pair_t;

endpackage

// File: rtl/edge_collector_fifo.sv
// rtl/edge_collector_fifo.sv - first-word-fall-through pair buffer with push/pop qualification
module edge_collector_fifo
  import edge_collector_pkg::*;
#(
  parameter int DATA_W = COLLECTOR_DATA_W,
  parameter int DEPTH  = COLLECTOR_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_c,
  input  logic [DATA_W-1:0]        in_f,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_c,
  output logic [DATA_W-1:0]        out_f,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push,
  output logic                     pop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] f;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);

  assign head  = mem[rd_ptr];
  assign out_c = out_valid ? head.c : '0;
  assign out_f = out_valid ? head.f : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{c: in_c, f: in_f};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/edge_result_collector.sv
// rtl/edge_result_collector.sv - buffers (c, f) result pairs, flags drops, optional f sum
// Optional running sum of f enabled by macro EDGE_COLLECTOR_SUM_EN.
module edge_result_collector
  import edge_collector_pkg::*;
#(
  parameter int DATA_W = COLLECTOR_DATA_W,
  parameter int DEPTH  = COLLECTOR_DEPTH
`ifdef EDGE_COLLECTOR_SUM_EN
  ,
  parameter int SUM_W  = COLLECTOR_SUM_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_c,
  input  logic [DATA_W-1:0]        in_f,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_c,
  output logic [DATA_W-1:0]        out_f,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef EDGE_COLLECTOR_SUM_EN
  ,
  output logic [SUM_W-1:0]         sum_f,
  output logic                     sum_sat
`endif
);

  logic push;
  logic pop;
  logic drop;

  edge_collector_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_c      (in_c),
    .in_f      (in_f),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_c     (out_c),
    .out_f     (out_f),
    .count     (count),
    .push      (push),
    .pop       (pop)
  );

  assign drop = in_valid && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef EDGE_COLLECTOR_SUM_EN
  // One spare bit above the wider operand so the true sum is never truncated.
  localparam int ACC_W = ((SUM_W > DATA_W) ? SUM_W : DATA_W) + 1;

  logic [ACC_W-1:0] sum_wide;
  logic             sum_over;

  assign sum_wide = ACC_W'(sum_f) + ACC_W'(in_f);
  assign sum_over = (sum_wide > ACC_W'({SUM_W{1'b1}}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_f   <= '0;
      sum_sat <= 1'b0;
    end else if (clear) begin
      sum_f   <= '0;
      sum_sat <= 1'b0;
    end else if (push) begin
      if (sum_over) begin
        sum_f   <= {SUM_W{1'b1}};
        sum_sat <= 1'b1;
      end else begin
        sum_f   <= sum_wide[SUM_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_edge_result_collector.sv
// tb/tb_edge_result_collector.sv - randomized self-checking bench with queue reference model
// Sum checks compile in when EDGE_COLLECTOR_SUM_EN is defined.
module tb_edge_result_collector;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SUM_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic [DATA_W-1:0]      in_c = '0;
  logic [DATA_W-1:0]      in_f = '0;
  logic                   clear = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DATA_W-1:0]      out_c;
  logic [DATA_W-1:0]      out_f;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
`ifdef EDGE_COLLECTOR_SUM_EN
  logic [SUM_W-1:0]       sum_f;
  logic                   sum_sat;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model: a queue of {c, f} pairs plus sticky flags.
  logic [2*DATA_W-1:0] mq[$];
  bit                  m_ovf = 0;
  int unsigned         m_sum = 0;
  bit                  m_sat = 0;

  always #5 clk = ~clk;

  edge_result_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_c      (in_c),
    .in_f      (in_f),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_f     (out_f),
    .count     (count),
    .overflow  (overflow)
`ifdef EDGE_COLLECTOR_SUM_EN
    ,
    .sum_f     (sum_f),
    .sum_sat   (sum_sat)
`endif
  );

  // Drive one cycle of inputs, advance the model at the edge, return at the next negedge.
  task automatic step(input bit iv, input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] f,
                      input bit rdy, input bit clr);
    bit do_pop;
    bit do_push;
    in_valid  = iv;
    in_c      = c;
    in_f      = f;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    do_pop  = (mq.size() != 0) && rdy;
    do_push = iv && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({c, f});
    if (clr) begin
      m_ovf = 0;
      m_sum = 0;
      m_sat = 0;
    end else begin
      if (iv && !do_push) m_ovf = 1;
      if (do_push) begin
        m_sum = m_sum + f;
        if (m_sum > 65535) begin
          m_sum = 65535;
          m_sat = 1;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, '0, '0, 1, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%0b exp=0", overflow); else passed++;
    total++; if (out_c !== '0 || out_f !== '0) $display("FAIL reset_data got=%0d/%0d exp=0/0", out_c, out_f); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    step(1, 8'd50, 8'd80, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL single_valid cyc=%0d got=%0b exp=1", i, out_valid); else passed++;
      total++; if (out_c !== 8'd50 || out_f !== 8'd80) $display("FAIL single_data cyc=%0d got=%0d/%0d exp=50/80", i, out_c, out_f); else passed++;
      total++; if (count !== 3'd1) $display("FAIL single_count cyc=%0d got=%0d exp=1", i, count); else passed++;
      if (i < 3) step(0, '0, '0, 0, 0);
    end
    drain();
    total++; if (out_valid !== 1'b0 || out_f !== '0) $display("FAIL single_drain got=%0b/%0d exp=0/0", out_valid, out_f); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) step(1, DATA_W'($urandom), DATA_W'(i), 0, 0);
    total++; if (count !== 3'd4) $display("FAIL ovf_count got=%0d exp=4", count); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%0b exp=1", overflow); else passed++;
    for (int i = 1; i <= 4; i++) begin
      total++; if (out_f !== DATA_W'(i)) $display("FAIL ovf_order idx=%0d got=%0d exp=%0d", i, out_f, i); else passed++;
      step(0, '0, '0, 1, 0);
    end
    total++; if (out_valid !== 1'b0 || out_f !== '0) $display("FAIL ovf_empty got=%0b/%0d exp=0/0", out_valid, out_f); else passed++;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) step(1, DATA_W'(i + 10), DATA_W'(i + 20), 0, 0);
    step(1, 8'd99, 8'd99, 0, 1);
    total++; if (overflow !== 1'b0) $display("FAIL clear_prio got=%0b exp=0", overflow); else passed++;
    step(1, 8'd98, 8'd98, 0, 0);
    total++; if (overflow !== 1'b1) $display("FAIL clear_reset got=%0b exp=1", overflow); else passed++;
    step(0, '0, '0, 0, 1);
    total++; if (overflow !== 1'b0) $display("FAIL clear_idle got=%0b exp=0", overflow); else passed++;
    total++; if (count !== 3'd4 || out_c !== 8'd10) $display("FAIL clear_keep got=%0d/%0d exp=4/10", count, out_c); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      total++; if ({out_c, out_f} !== mq[0]) $display("FAIL b2b_head cyc=%0d got=%h exp=%h", i, {out_c, out_f}, mq[0]); else passed++;
      step(1, DATA_W'(i + 40), DATA_W'(i + 60), 1, 0);
      total++; if (count !== 3'd4 || overflow !== 1'b0) $display("FAIL b2b_state cyc=%0d got=%0d/%0b exp=4/0", i, count, overflow); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_c !== DATA_W'(i + 42) || out_f !== DATA_W'(i + 62)) $display("FAIL b2b_wrap idx=%0d got=%0d/%0d exp=%0d/%0d", i, out_c, out_f, i + 42, i + 62); else passed++;
      step(0, '0, '0, 1, 0);
    end
  endtask

`ifdef EDGE_COLLECTOR_SUM_EN
  task automatic test_sum();
    step(0, '0, '0, 0, 1);
    for (int i = 0; i < 400; i++) step(1, DATA_W'(i), 8'd200, 1, 0);
    total++; if (sum_f !== 16'd65535 || sum_f !== SUM_W'(m_sum)) $display("FAIL sum_sat_val got=%0d exp=65535", sum_f); else passed++;
    total++; if (sum_sat !== 1'b1) $display("FAIL sum_sat_flag got=%0b exp=1", sum_sat); else passed++;
    step(1, 8'd7, 8'd9, 0, 1);
    total++; if (sum_f !== '0 || sum_sat !== 1'b0) $display("FAIL sum_clear got=%0d/%0b exp=0/0", sum_f, sum_sat); else passed++;
    total++; if (count !== 3'd2) $display("FAIL sum_clear_store got=%0d exp=2", count); else passed++;
    step(0, '0, '0, 1, 0);
    total++; if (out_c !== 8'd7 || out_f !== 8'd9) $display("FAIL sum_clear_pair got=%0d/%0d exp=7/9", out_c, out_f); else passed++;
    drain();
  endtask
`endif

  task automatic test_async_reset();
    drain();
    for (int i = 0; i < 5; i++) step(1, DATA_W'(i + 1), DATA_W'(i + 1), 0, 0);
    step(0, '0, '0, 1, 0);
    total++; if (count !== 3'd3 || overflow !== 1'b1) $display("FAIL arst_pre got=%0d/%0b exp=3/1", count, overflow); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || count !== '0) $display("FAIL arst_drop got=%0b/%0d exp=0/0", out_valid, count); else passed++;
    total++; if (overflow !== 1'b0 || out_c !== '0 || out_f !== '0) $display("FAIL arst_flags got=%0b/%0d/%0d exp=0/0/0", overflow, out_c, out_f); else passed++;
    mq.delete();
    m_ovf = 0;
    m_sum = 0;
    m_sat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'd33, 8'd44, 0, 0);
    total++; if (count !== 3'd1 || out_c !== 8'd33 || out_f !== 8'd44) $display("FAIL arst_first got=%0d/%0d/%0d exp=1/33/44", count, out_c, out_f); else passed++;
  endtask

  task automatic test_random();
    logic [2*DATA_W-1:0] exp_head;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), DATA_W'($urandom), DATA_W'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      exp_head = (mq.size() != 0) ? mq[0] : '0;
      total++; if (out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, out_valid, mq.size() != 0); else passed++;
      total++; if (count !== 3'(mq.size())) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, mq.size()); else passed++;
      total++; if ({out_c, out_f} !== exp_head) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, {out_c, out_f}, exp_head); else passed++;
      total++; if (overflow !== m_ovf) $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", i, overflow, m_ovf); else passed++;
`ifdef EDGE_COLLECTOR_SUM_EN
      total++; if (sum_f !== SUM_W'(m_sum) || sum_sat !== m_sat) $display("FAIL rnd_sum cyc=%0d got=%0d/%0b exp=%0d/%0b", i, sum_f, sum_sat, m_sum, m_sat); else passed++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_clear();
    test_back_to_back();
`ifdef EDGE_COLLECTOR_SUM_EN
    test_sum();
`endif
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
